dmem_demux4: RTL and testbench

Address-decoded 1-to-4 data-memory request demultiplexer for the RV32I core's load/store path. Takes one request from the core's data port, routes it to one of four targets (RAM, UART, timer, GPIO), and returns the selected target's response. One transaction is outstanding at a time. Requests and responses are registered on both sides.

---
 rtl/dmem_demux_pkg.sv | 24 ++
 rtl/dmem_addr_decode.sv | 25 ++
 rtl/dmem_demux4.sv | 177 +++++++++++++++++
 tb/tb_dmem_demux4.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_demux_pkg
//  Purpose  : Shared state encoding, target indices and error data for the
//             data-memory request demultiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_demux_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    localparam logic [1:0] TGT_RAM   = 2'd0;
    localparam logic [1:0] TGT_UART  = 2'd1;
    localparam logic [1:0] TGT_TIMER = 2'd2;
    localparam logic [1:0] TGT_GPIO  = 2'd3;

    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage : dmem_demux_pkg
`default_nettype wire

// File: rtl/dmem_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_addr_decode
//  Purpose  : 2-bit target select to 4-bit one-hot, forced to zero when the
//             valid input is low.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_addr_decode
    import dmem_demux_pkg::*;
(
    input  logic       i_valid,
    input  logic [1:0] i_sel,
    output logic [3:0] o_onehot
);

    always_comb begin
        o_onehot            = '0;
        o_onehot[TGT_RAM]   = i_valid && (i_sel == TGT_RAM);
        o_onehot[TGT_UART]  = i_valid && (i_sel == TGT_UART);
        o_onehot[TGT_TIMER] = i_valid && (i_sel == TGT_TIMER);
        o_onehot[TGT_GPIO]  = i_valid && (i_sel == TGT_GPIO);
    end

endmodule : dmem_addr_decode
`default_nettype wire

// File: rtl/dmem_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_demux4
//  Purpose  : Address-decoded 1-to-4 data-memory request demultiplexer with a
//             single outstanding transaction. Optional response watchdog is
//             enabled by defining DMEM_DEMUX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_demux4
    import dmem_demux_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SEL_MSB = 31,
    parameter int TIMEOUT = 255
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    // core side
    input  logic                 m_req_valid,
    output logic                 m_req_ready,
    input  logic [WIDTH-1:0]     m_addr,
    input  logic                 m_we,
    input  logic [3:0]           m_wstrb,
    input  logic [WIDTH-1:0]     m_wdata,
    output logic                 m_rsp_valid,
    output logic [WIDTH-1:0]     m_rdata,
    output logic                 m_rsp_err,
    // target side
    output logic [3:0]           s_req_valid,
    input  logic [3:0]           s_req_ready,
    output logic [WIDTH-1:0]     s_addr,
    output logic                 s_we,
    output logic [3:0]           s_wstrb,
    output logic [WIDTH-1:0]     s_wdata,
    input  logic [3:0]           s_rsp_valid,
    input  logic [4*WIDTH-1:0]   s_rdata
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_sel;
    logic               r_req_ready;
    logic [WIDTH-1:0]   r_addr;
    logic               r_we;
    logic [3:0]         r_wstrb;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_rsp_valid;

    logic               w_accept;
    logic               w_ready_sel;
    logic               w_rsp_sel;
    logic               w_busy;
    logic               w_done;
    logic               w_timeout;
    logic [WIDTH-1:0]   w_rdata_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign w_rdata_arr[gi] = s_rdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Ready is registered so it reads low while reset is held.
    assign w_accept    = (r_state == IDLE) && r_req_ready && m_req_valid;
    assign w_ready_sel = s_req_ready[r_sel];
    assign w_rsp_sel   = s_rsp_valid[r_sel];
    assign w_busy      = (r_state == REQ) || (r_state == WAIT_RSP);
    assign w_done      = (r_state == WAIT_RSP) && w_rsp_sel;

`ifdef DMEM_DEMUX_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_rsp_err;

    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    // A response arriving on the final cycle still completes normally.
    assign w_timeout = w_busy && !w_done && (w_cnt_inc == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_timeout;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_busy) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign m_rsp_err = r_rsp_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_timeout        = 1'b0;
    assign m_rsp_err        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else if (w_ready_sel) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= 2'd0;
            r_req_ready <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= w_done || w_timeout;
            if (w_accept) begin
                r_sel   <= m_addr[SEL_MSB -: 2];
                r_addr  <= m_addr;
                r_we    <= m_we;
                r_wstrb <= m_wstrb;
                r_wdata <= m_wdata;
            end
            if (w_done) begin
                r_rdata <= w_rdata_arr[r_sel];
            end else if (w_timeout) begin
                r_rdata <= WIDTH'(ERR_RDATA);
            end
        end
    end

    dmem_addr_decode u_decode (
        .i_valid  (r_state == REQ),
        .i_sel    (r_sel),
        .o_onehot (s_req_valid)
    );

    assign m_req_ready = r_req_ready;
    assign m_rsp_valid = r_rsp_valid;
    assign m_rdata     = r_rdata;
    assign s_addr      = r_addr;
    assign s_we        = r_we;
    assign s_wstrb     = r_wstrb;
    assign s_wdata     = r_wdata;

endmodule : dmem_demux4
`default_nettype wire

// File: tb/tb_dmem_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_demux4
//  Purpose  : Directed, scoreboard-checked bench for dmem_demux4.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_demux4;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           m_req_valid;
    logic           m_req_ready;
    logic [W-1:0]   m_addr;
    logic           m_we;
    logic [3:0]     m_wstrb;
    logic [W-1:0]   m_wdata;
    logic           m_rsp_valid;
    logic [W-1:0]   m_rdata;
    logic           m_rsp_err;
    logic [3:0]     s_req_valid;
    logic [3:0]     s_req_ready;
    logic [W-1:0]   s_addr;
    logic           s_we;
    logic [3:0]     s_wstrb;
    logic [W-1:0]   s_wdata;
    logic [3:0]     s_rsp_valid;
    logic [4*W-1:0] s_rdata;

    dmem_demux4 #(.WIDTH(W), .SEL_MSB(31), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_addr      (m_addr),
        .m_we        (m_we),
        .m_wstrb     (m_wstrb),
        .m_wdata     (m_wdata),
        .m_rsp_valid (m_rsp_valid),
        .m_rdata     (m_rdata),
        .m_rsp_err   (m_rsp_err),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_addr      (s_addr),
        .s_we        (s_we),
        .s_wstrb     (s_wstrb),
        .s_wdata     (s_wdata),
        .s_rsp_valid (s_rsp_valid),
        .s_rdata     (s_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [31:0] rd [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nerrors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Response monitor: every m_rsp_valid pulse must match the queue head.
    always @(negedge clk) begin
        if (m_rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                nchecks++;
                nerrors++;
                $display("FAIL unexpected_rsp: got response rdata %h at cycle %0d, expected none", m_rdata, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_err", {31'd0, m_rsp_err}, {31'd0, mon_e.err});
                if (mon_e.chk_rdata) chk("rsp_rdata", m_rdata, mon_e.rdata);
                chk("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] st,
                         input logic [31:0] wd, output int acc);
        logic r;
        bit   got;
        got = 1'b0;
        acc = -1;
        m_addr = a; m_we = we; m_wstrb = st; m_wdata = wd; m_req_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            r = m_req_ready;
            @(posedge clk); #1;
            if (r) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        m_req_valid = 1'b0; m_addr = '0; m_we = 1'b0; m_wstrb = '0; m_wdata = '0;
        nchecks++;
        if (!got) begin
            nerrors++;
            $display("FAIL accept_timeout: got no acceptance for addr %h, expected within 20 cycles", a);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_req_ready"}, {31'd0, m_req_ready}, 32'd0);
        chk({tag, "_m_rsp_valid"}, {31'd0, m_rsp_valid}, 32'd0);
        chk({tag, "_m_rsp_err"},   {31'd0, m_rsp_err},   32'd0);
        chk({tag, "_m_rdata"},     m_rdata,              32'd0);
        chk({tag, "_s_req_valid"}, {28'd0, s_req_valid}, 32'd0);
        chk({tag, "_s_addr"},      s_addr,               32'd0);
        chk({tag, "_s_we"},        {31'd0, s_we},        32'd0);
        chk({tag, "_s_wstrb"},     {28'd0, s_wstrb},     32'd0);
        chk({tag, "_s_wdata"},     s_wdata,              32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion before 200000 ns");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int acc;
        int prev;
        int cnt;

        rd[0] = 32'hCAFE_0000;
        rd[1] = 32'h1234_5678;
        rd[2] = 32'h2222_AAAA;
        rd[3] = 32'h3333_5555;
        rst_n = 1'b0;
        m_req_valid = 1'b0; m_addr = '0; m_we = 1'b0; m_wstrb = '0; m_wdata = '0;
        s_req_ready = '0; s_rsp_valid = '0;
        s_rdata = {rd[3], rd[2], rd[1], rd[0]};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all_zero("init");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // UART load, ready and response immediate
        s_req_ready = 4'b0010; s_rsp_valid = 4'b0010;
        issue(32'h4000_0010, 1'b0, 4'b0000, 32'd0, acc);
        q.push_back(exp_t'{32'h1234_5678, 1'b1, 1'b0, acc + 2});
        @(negedge clk);
        chk("t1_sreqv_req",  {28'd0, s_req_valid}, 32'h2);
        chk("t1_mready_req", {31'd0, m_req_ready}, 32'd0);
        chk("t1_saddr",      s_addr, 32'h4000_0010);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_sreqv_wait", {28'd0, s_req_valid}, 32'd0);
        @(posedge clk); #1;
        s_req_ready = '0; s_rsp_valid = '0;

        // GPIO store with ready held off for 4 cycles
        issue(32'hC000_0004, 1'b1, 4'b0011, 32'hA5A5_5A5A, acc);
        q.push_back(exp_t'{32'd0, 1'b0, 1'b0, acc + 6});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_sreqv",  {28'd0, s_req_valid}, 32'h8);
            chk("st_saddr",  s_addr, 32'hC000_0004);
            chk("st_swe",    {31'd0, s_we}, 32'd1);
            chk("st_swstrb", {28'd0, s_wstrb}, 32'h3);
            chk("st_swdata", s_wdata, 32'hA5A5_5A5A);
            @(posedge clk); #1;
        end
        s_req_ready = 4'b1000;
        @(posedge clk); #1;
        s_req_ready = '0; s_rsp_valid = 4'b1000;
        @(posedge clk); #1;
        s_rsp_valid = '0;

        // RAM load with spurious responses from the other targets
        s_req_ready = 4'b0001;
        issue(32'h0000_0100, 1'b0, 4'b0000, 32'd0, acc);
        q.push_back(exp_t'{32'hCAFE_0000, 1'b1, 1'b0, acc + 5});
        @(posedge clk); #1;
        s_rsp_valid = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spur_no_rsp", {31'd0, m_rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        s_rsp_valid = 4'b0001;
        @(posedge clk); #1;
        s_rsp_valid = '0; s_req_ready = '0;

        // Back-to-back loads across all four targets
        s_req_ready = 4'hF; s_rsp_valid = 4'hF;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            issue({2'(k), 30'h0000_0040}, 1'b0, 4'b0000, 32'd0, acc);
            q.push_back(exp_t'{rd[k], 1'b1, 1'b0, acc + 2});
            if (k > 0) chk("b2b_gap", acc - prev, 32'd3);
            prev = acc;
        end
        repeat (2) @(posedge clk);
        #1;
        s_req_ready = '0; s_rsp_valid = '0;

        // Reset while waiting for a timer response
        s_req_ready = 4'b0100;
        issue(32'h8000_0020, 1'b0, 4'b0000, 32'd0, acc);
        @(posedge clk); #1;
        s_req_ready = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_rsp_valid = 4'b0100;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_rsp_valid === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        s_rsp_valid = '0;
        chk("midrst_no_rsp", cnt, 32'd0);
        @(negedge clk);
        chk("midrst_idle_ready", {31'd0, m_req_ready}, 32'd1);
        @(posedge clk); #1;

        // Target that accepts but never responds
        s_req_ready = 4'b0010;
        issue(32'h4000_0000, 1'b0, 4'b0000, 32'd0, acc);
`ifdef DMEM_DEMUX_TIMEOUT_EN
        q.push_back(exp_t'{32'hDEADBEEF, 1'b1, 1'b1, acc + 16});
`endif
        @(posedge clk); #1;
        s_req_ready = '0;
`ifdef DMEM_DEMUX_TIMEOUT_EN
        repeat (20) @(posedge clk);
        #1;
`else
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_rsp_valid === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        chk("noto_no_rsp", cnt, 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule : tb_dmem_demux4
`default_nettype wire
